// File: rtl/face_result_writer_if.sv
// Result-writer handshake from the detection engine plus the overlay BRAM write port.
// The writer block uses the slave modport; the engine/bench side uses master.
interface face_result_writer_if #(
   parameter int WIDTH_POSI      = 8,
   parameter int WIDTH_DISP_ADDR = 15
);
   logic                       write_result_start;
   logic [WIDTH_POSI-1:0]      xpos;
   logic [WIDTH_POSI-1:0]      ypos;
   logic [WIDTH_POSI-1:0]      length;
   logic                       write_result_done;
   logic                       busy;
   logic                       we_disp;
   logic [WIDTH_DISP_ADDR-1:0] addr_disp;
   logic                       din_disp;

   modport master (
      output write_result_start, xpos, ypos, length,
      input  write_result_done, busy, we_disp, addr_disp, din_disp
   );

   modport slave (
      input  write_result_start, xpos, ypos, length,
      output write_result_done, busy, we_disp, addr_disp, din_disp
   );
endinterface

// File: rtl/face_result_writer.sv
// Draws a detected window's square outline into the 1-bit overlay BRAM, one pixel per clock.
// Optional macro RESULT_WRITER_CLEAR_EN: erase the previously drawn box before drawing the new one.
//
// state      | meaning
// IDLE       | waiting for write_result_start
// CLR_TOP    | erasing top edge of previous box (clear option only)
// CLR_BOTTOM | erasing bottom edge of previous box (clear option only)
// CLR_LEFT   | erasing left edge of previous box (clear option only)
// CLR_RIGHT  | erasing right edge of previous box (clear option only)
// TOP        | drawing top edge
// BOTTOM     | drawing bottom edge
// LEFT       | drawing left edge (between the corners)
// RIGHT      | drawing right edge (between the corners)
// DONE       | one-cycle done pulse
module face_result_writer #(
   parameter int WIDTH_POSI      = 8,
   parameter int WIDTH_DISP_ADDR = 15,
   parameter int IMG_W           = 160,
   parameter int IMG_H           = 120
) (
   input  logic                clk,
   input  logic                rst,
   face_result_writer_if.slave res_if
);
   localparam int WC = WIDTH_POSI + 1;
   typedef logic [WC-1:0] crd_t;

   typedef enum logic [3:0] {
      IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE
`ifdef RESULT_WRITER_CLEAR_EN
      , CLR_TOP, CLR_BOTTOM, CLR_LEFT, CLR_RIGHT
`endif
   } state_t;

   state_t                     state_q, state_d;
   crd_t                       cnt_q, cnt_d;
   logic [WIDTH_POSI-1:0]      bx_q, bx_d, by_q, by_d, bl_q, bl_d;
   logic                       we_q, we_d, din_q, din_d, done_q, done_d, busy_q, busy_d;
   logic [WIDTH_DISP_ADDR-1:0] addr_q, addr_d;
   crd_t                       sx, sy, sl, px_x, px_y, len_cur;
   logic                       pix;
`ifdef RESULT_WRITER_CLEAR_EN
   logic [WIDTH_POSI-1:0]      px_q, px_d, py_q, py_d, pl_q, pl_d;
   logic                       pv_q, pv_d;

   function automatic logic is_clr(state_t s);
      return (s == CLR_TOP) || (s == CLR_BOTTOM) || (s == CLR_LEFT) || (s == CLR_RIGHT);
   endfunction
`endif

   // First non-empty edge after s for a box of side l; IDLE means "before the top edge".
   function automatic state_t next_draw(state_t s, crd_t l);
      state_t n;
      n = DONE;
      case (s)
         TOP:     if (l >= crd_t'(2)) n = BOTTOM;
         BOTTOM:  if (l >= crd_t'(3)) n = LEFT;
         LEFT:    n = RIGHT;
         RIGHT:   n = DONE;
         default: if (l >= crd_t'(1)) n = TOP;
      endcase
      return n;
   endfunction

`ifdef RESULT_WRITER_CLEAR_EN
   function automatic state_t next_clr(state_t s, crd_t lp, crd_t l);
      state_t n;
      case (s)
         CLR_TOP:    n = (lp >= crd_t'(2)) ? CLR_BOTTOM : next_draw(IDLE, l);
         CLR_BOTTOM: n = (lp >= crd_t'(3)) ? CLR_LEFT : next_draw(IDLE, l);
         CLR_LEFT:   n = CLR_RIGHT;
         CLR_RIGHT:  n = next_draw(IDLE, l);
         default:    n = (lp >= crd_t'(1)) ? CLR_TOP : next_draw(IDLE, l);
      endcase
      return n;
   endfunction
`endif

   // Horizontal edges span the full side; vertical edges exclude both corners.
   function automatic crd_t edge_last(state_t s, crd_t l);
      case (s)
         TOP, BOTTOM
`ifdef RESULT_WRITER_CLEAR_EN
         , CLR_TOP, CLR_BOTTOM
`endif
                  : return l - crd_t'(1);
         default: return l - crd_t'(3);
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bx_d    = bx_q;
      by_d    = by_q;
      bl_d    = bl_q;
      len_cur = crd_t'(bl_q);
`ifdef RESULT_WRITER_CLEAR_EN
      px_d = px_q;
      py_d = py_q;
      pl_d = pl_q;
      pv_d = pv_q;
`endif
      case (state_q)
         IDLE: begin
            if (res_if.write_result_start) begin
               bx_d  = res_if.xpos;
               by_d  = res_if.ypos;
               bl_d  = res_if.length;
               cnt_d = '0;
`ifdef RESULT_WRITER_CLEAR_EN
               if (pv_q) state_d = next_clr(IDLE, crd_t'(pl_q), crd_t'(res_if.length));
               else
`endif
               state_d = next_draw(IDLE, crd_t'(res_if.length));
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef RESULT_WRITER_CLEAR_EN
            px_d = bx_q;
            py_d = by_q;
            pl_d = bl_q;
            pv_d = 1'b1;
`endif
         end
         default: begin
`ifdef RESULT_WRITER_CLEAR_EN
            if (is_clr(state_q)) len_cur = crd_t'(pl_q);
`endif
            if (cnt_q == edge_last(state_q, len_cur)) begin
               cnt_d = '0;
`ifdef RESULT_WRITER_CLEAR_EN
               if (is_clr(state_q)) state_d = next_clr(state_q, crd_t'(pl_q), crd_t'(bl_q));
               else
`endif
               state_d = next_draw(state_q, crd_t'(bl_q));
            end else begin
               cnt_d = cnt_q + crd_t'(1);
            end
         end
      endcase

      // Outputs are registered from the next state so pixel 1 appears the cycle after start.
      sx    = crd_t'(bx_d);
      sy    = crd_t'(by_d);
      sl    = crd_t'(bl_d);
      din_d = 1'b1;
`ifdef RESULT_WRITER_CLEAR_EN
      if (is_clr(state_d)) begin
         sx    = crd_t'(px_q);
         sy    = crd_t'(py_q);
         sl    = crd_t'(pl_q);
         din_d = 1'b0;
      end
`endif
      px_x = '0;
      px_y = '0;
      pix  = 1'b1;
      case (state_d)
         TOP
`ifdef RESULT_WRITER_CLEAR_EN
         , CLR_TOP
`endif
         : begin
            px_x = sx + cnt_d;
            px_y = sy;
         end
         BOTTOM
`ifdef RESULT_WRITER_CLEAR_EN
         , CLR_BOTTOM
`endif
         : begin
            px_x = sx + cnt_d;
            px_y = sy + sl - crd_t'(1);
         end
         LEFT
`ifdef RESULT_WRITER_CLEAR_EN
         , CLR_LEFT
`endif
         : begin
            px_x = sx;
            px_y = sy + crd_t'(1) + cnt_d;
         end
         RIGHT
`ifdef RESULT_WRITER_CLEAR_EN
         , CLR_RIGHT
`endif
         : begin
            px_x = sx + sl - crd_t'(1);
            px_y = sy + crd_t'(1) + cnt_d;
         end
         default: begin
            pix   = 1'b0;
            din_d = 1'b0;
         end
      endcase
      we_d   = pix && (px_x < crd_t'(IMG_W)) && (px_y < crd_t'(IMG_H));
      addr_d = we_d ? WIDTH_DISP_ADDR'(32'(px_y) * IMG_W + 32'(px_x)) : '0;
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         bl_q    <= '0;
         we_q    <= 1'b0;
         din_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
`ifdef RESULT_WRITER_CLEAR_EN
         px_q    <= '0;
         py_q    <= '0;
         pl_q    <= '0;
         pv_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         bl_q    <= bl_d;
         we_q    <= we_d;
         din_q   <= din_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
`ifdef RESULT_WRITER_CLEAR_EN
         px_q    <= px_d;
         py_q    <= py_d;
         pl_q    <= pl_d;
         pv_q    <= pv_d;
`endif
      end
   end

   assign res_if.we_disp           = we_q;
   assign res_if.addr_disp         = addr_q;
   assign res_if.din_disp          = din_q;
   assign res_if.write_result_done = done_q;
   assign res_if.busy              = busy_q;
endmodule

// File: tb/tb_face_result_writer.sv
// Scoreboard bench for face_result_writer: a box model queues expected writes and done cycles,
// a negedge monitor pops and compares; per-run hand-computed counts and addresses are checked too.
module tb_face_result_writer;
   localparam int WP = 8;
   localparam int WA = 15;

   typedef struct {
      int cyc;
      int addr;
      bit din;
   } wr_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   int   wr_cnt;
   int   done_cnt;
   int   first_addr;
   int   last_addr;
   int   done_seen;
   wr_t  exp_wr[$];
   int   exp_done[$];
   bit   tb_pv;
   int   tb_px, tb_py, tb_pl;

   face_result_writer_if #(.WIDTH_POSI(WP), .WIDTH_DISP_ADDR(WA)) bus ();

   face_result_writer #(
      .WIDTH_POSI(WP), .WIDTH_DISP_ADDR(WA), .IMG_W(160), .IMG_H(120)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .res_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.we_disp) begin
            wr_t e;
            wr_cnt++;
            if (wr_cnt == 1) first_addr = int'(bus.addr_disp);
            last_addr = int'(bus.addr_disp);
            total++;
            if (exp_wr.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write addr=%0d din=%0b cyc=%0d", bus.addr_disp, bus.din_disp, cyc);
            end else begin
               e = exp_wr.pop_front();
               if (e.addr != int'(bus.addr_disp) || e.din != bus.din_disp || e.cyc != cyc) begin
                  bad++;
                  $display("FAIL write got addr=%0d din=%0b cyc=%0d want addr=%0d din=%0b cyc=%0d",
                           bus.addr_disp, bus.din_disp, cyc, e.addr, e.din, e.cyc);
               end
            end
         end
         if (bus.write_result_done) begin
            done_cnt++;
            done_seen = cyc;
            total++;
            if (exp_done.size() == 0) begin
               bad++;
               $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
               int ed;
               ed = exp_done.pop_front();
               if (ed != cyc || bus.busy !== 1'b1) begin
                  bad++;
                  $display("FAIL done_timing got cyc=%0d busy=%0b want cyc=%0d busy=1", cyc, bus.busy, ed);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic push_px(input int x, input int y, input bit din, inout int c);
      if (x < 160 && y < 120) exp_wr.push_back('{cyc: c, addr: y * 160 + x, din: din});
      c++;
   endtask

   task automatic push_box(input int x, input int y, input int l, input bit din, inout int c);
      for (int i = 0; i < l; i++) push_px(x + i, y, din, c);
      if (l >= 2) for (int i = 0; i < l; i++) push_px(x + i, y + l - 1, din, c);
      if (l >= 3) for (int i = 1; i <= l - 2; i++) push_px(x, y + i, din, c);
      if (l >= 3) for (int i = 1; i <= l - 2; i++) push_px(x + l - 1, y + i, din, c);
   endtask

   // Expected traffic for one start accepted at the posedge where cyc becomes s.
   task automatic model_run(input int x, input int y, input int l, input int s);
      int c;
      c = s;
`ifdef RESULT_WRITER_CLEAR_EN
      if (tb_pv) push_box(tb_px, tb_py, tb_pl, 1'b0, c);
      tb_pv = 1'b1;
      tb_px = x;
      tb_py = y;
      tb_pl = l;
`endif
      push_box(x, y, l, 1'b1, c);
      exp_done.push_back(c);
   endtask

   // Caller is at negedge+1; start is sampled at the next posedge (cycle 0 of this run).
   task automatic run_box(input string nm, input int x, input int y, input int l, input bit guard,
                          input int h_wr, input int h_done, input int h_first, input int h_last);
      int  s;
      bit  got;
      s = cyc + 1;
      model_run(x, y, l, s);
      wr_cnt     = 0;
      first_addr = -1;
      last_addr  = -1;
      bus.xpos   = WP'(x);
      bus.ypos   = WP'(y);
      bus.length = WP'(l);
      bus.write_result_start = 1'b1;
      @(negedge clk); #1;
      if (guard) begin
         bus.xpos   = WP'(90);
         bus.ypos   = WP'(90);
         bus.length = WP'(5);
      end else begin
         bus.write_result_start = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (exp_done.size() == 0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_timeout no done within budget", nm);
      end
      chk({nm, "_busy_in_done"}, int'(bus.busy), 1);
      chk({nm, "_done_cycle"}, done_seen - s + 1, h_done);
      @(negedge clk); #1;
      chk({nm, "_busy_after"}, int'(bus.busy), 0);
      chk({nm, "_done_low_after"}, int'(bus.write_result_done), 0);
      bus.write_result_start = 1'b0;
      chk({nm, "_writes"}, wr_cnt, h_wr);
      chk({nm, "_pending"}, exp_wr.size(), 0);
      if (h_wr > 0) begin
         chk({nm, "_first_addr"}, first_addr, h_first);
         chk({nm, "_last_addr"}, last_addr, h_last);
      end
   endtask

   initial begin
      int s;
      cyc = 0;
      total = 0;
      bad = 0;
      wr_cnt = 0;
      done_cnt = 0;
      done_seen = -1;
      tb_pv = 1'b0;
      tb_px = 0;
      tb_py = 0;
      tb_pl = 0;
      rst = 1'b1;
      bus.write_result_start = 1'b0;
      bus.xpos   = '0;
      bus.ypos   = '0;
      bus.length = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_outputs", int'({bus.we_disp, bus.din_disp, bus.write_result_done, bus.busy}), 0);
      chk("reset_addr", int'(bus.addr_disp), 0);
      rst = 1'b0;
      @(negedge clk); #1;

      // Abort a normal box in cycle 5 with an async reset.
      s = cyc + 1;
      model_run(10, 20, 4, s);
      wr_cnt = 0;
      bus.xpos = WP'(10);
      bus.ypos = WP'(20);
      bus.length = WP'(4);
      bus.write_result_start = 1'b1;
      @(negedge clk); #1;
      bus.write_result_start = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
      end
      chk("pre_reset_writes", wr_cnt, 5);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", int'({bus.we_disp, bus.din_disp, bus.write_result_done, bus.busy}), 0);
      chk("midrst_addr", int'(bus.addr_disp), 0);
      exp_wr.delete();
      exp_done.delete();
      tb_pv = 1'b0;
      wr_cnt = 0;
      done_cnt = 0;
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk); #1;
      end
      chk("post_reset_done", done_cnt, 0);
      chk("post_reset_writes", wr_cnt, 0);
      chk("post_reset_busy", int'(bus.busy), 0);

      // Last address is the final pixel in draw order: the lower end of the right edge.
`ifdef RESULT_WRITER_CLEAR_EN
      run_box("normal",   10,  20, 4, 1'b0, 12, 13, 3210,  3533);
      run_box("second",   50,  60, 4, 1'b0, 24, 25, 3210,  9973);
      run_box("len0",      5,   5, 0, 1'b0, 12, 13, 9650,  9973);
      run_box("len1",      7,   3, 1, 1'b0,  1,  2,  487,   487);
      run_box("len2",      0,   0, 2, 1'b0,  5,  6,  487,   161);
      run_box("clip",    158, 118, 4, 1'b0,  7, 17,    0, 19198);
      run_box("guard",    10,  20, 4, 1'b1, 15, 25, 19038, 3533);
      run_box("offframe", 255, 255, 3, 1'b0, 12, 21, 3210,  3533);
`else
      run_box("normal",   10,  20, 4, 1'b0, 12, 13, 3210,  3533);
      run_box("second",   50,  60, 4, 1'b0, 12, 13, 9650,  9973);
      run_box("len0",      5,   5, 0, 1'b0,  0,  1,    0,     0);
      run_box("len1",      7,   3, 1, 1'b0,  1,  2,  487,   487);
      run_box("len2",      0,   0, 2, 1'b0,  4,  5,    0,   161);
      run_box("clip",    158, 118, 4, 1'b0,  3, 13, 19038, 19198);
      run_box("guard",    10,  20, 4, 1'b1, 12, 13, 3210,  3533);
      run_box("offframe", 255, 255, 3, 1'b0,  0,  9,    0,     0);
`endif

      wr_cnt = 0;
      repeat (20) begin
         @(negedge clk); #1;
      end
      chk("idle_no_writes", wr_cnt, 0);
      chk("final_pending_done", exp_done.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
